// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage 48-bit pipelined CPU.
// Holds opcodes, control-word layout, forwarding selects and pipeline-register structs.
package cpu_pkg;

    localparam int SIZE_DEFAULT = 48;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LDR  = 4'd6,
        OP_STR  = 4'd7,
        OP_BEQ  = 4'd8
    } opcode_e;

    localparam int CB_REGWRITE = 6;
    localparam int CB_MEMWRITE = 5;
    localparam int CB_MEMTOREG = 4;
    localparam int CB_ALUSRC   = 3;
    localparam int CB_BRANCH   = 2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef logic [6:0] ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic [SIZE_DEFAULT-1:0] instr;
        logic [SIZE_DEFAULT-1:0] pc;
    } fd_t;

    typedef struct packed {
        ctrl_t                   ctrl;
        logic [SIZE_DEFAULT-1:0] pc;
        logic [SIZE_DEFAULT-1:0] rd1;
        logic [SIZE_DEFAULT-1:0] rd2;
        logic [SIZE_DEFAULT-1:0] imm;
        logic [3:0]              rd;
        logic [3:0]              rs1;
        logic [3:0]              rs2;
    } de_t;

    typedef struct packed {
        ctrl_t                   ctrl;
        logic [SIZE_DEFAULT-1:0] alu;
        logic [SIZE_DEFAULT-1:0] wdata;
        logic [3:0]              rd;
    } em_t;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_to_reg;
        logic [SIZE_DEFAULT-1:0] alu;
        logic [SIZE_DEFAULT-1:0] rdata;
        logic [3:0]              rd;
    } mw_t;

    // Unused opcodes 9-15 fall through to an all-zero (NOP) control word.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        case (op)
            OP_ADD:  decode_ctrl = 7'b1000000;
            OP_SUB:  decode_ctrl = 7'b1000001;
            OP_AND:  decode_ctrl = 7'b1000010;
            OP_OR:   decode_ctrl = 7'b1000011;
            OP_ADDI: decode_ctrl = 7'b1001000;
            OP_LDR:  decode_ctrl = 7'b1011000;
            OP_STR:  decode_ctrl = 7'b0101000;
            OP_BEQ:  decode_ctrl = 7'b0000101;
            default: decode_ctrl = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/cpu_hazard_unit.sv
// Hazard logic: E-stage operand forwarding selects, load-use stall and branch flush.
module cpu_hazard_unit
    import cpu_pkg::*;
(
    input  logic [3:0] rs1_d,
    input  logic [3:0] rs2_d,
    input  logic [3:0] rs1_e,
    input  logic [3:0] rs2_e,
    input  logic [3:0] rd_e,
    input  logic [3:0] rd_m,
    input  logic [3:0] rd_w,
    input  logic       load_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       taken_e,
    output fwd_e       fwd_a,
    output fwd_e       fwd_b,
    output logic       stall,
    output logic       flush
);

    // M-stage producer wins over W-stage producer; R0 is never forwarded.
    function automatic fwd_e pick_src(input logic [3:0] rs, input logic [3:0] rdm,
                                      input logic [3:0] rdw, input logic wm, input logic ww);
        if (wm && (rdm == rs) && (rs != 4'd0)) begin
            pick_src = FWD_M;
        end else if (ww && (rdw == rs) && (rs != 4'd0)) begin
            pick_src = FWD_W;
        end else begin
            pick_src = FWD_RF;
        end
    endfunction

    // Combinational hazard decisions.
    always_comb begin
        fwd_a = pick_src(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
        fwd_b = pick_src(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);
        flush = taken_e;
        if (load_e && (rd_e != 4'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d))) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_pipelined.sv
// 5-stage in-order pipelined CPU (F/D/E/M/W) with forwarding, load-use stall
// and E-stage branch resolution; instruction ROM and data memory are external.
module cpu_pipelined
    import cpu_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic            MASTER_CLK,
    input  logic            Reset,
    input  logic [SIZE-1:0] Instr,
    input  logic [SIZE-1:0] ReadDataM,
    output logic            MemWriteM,
    output logic [SIZE-1:0] PCF,
    output logic [SIZE-1:0] ALUOutM,
    output logic [SIZE-1:0] WriteDataM,
    output logic [1:0]      MemoryControl,
    output logic [SIZE-1:0] iD,
    output logic [6:0]      Ctrl_D,
    output logic [6:0]      Ctrl_E,
    output logic [6:0]      Ctrl_M
);

    logic [SIZE-1:0] pc_r;
    fd_t             fd_r;
    de_t             de_r;
    em_t             em_r;
    mw_t             mw_r;
    logic [SIZE-1:0] rf_r [16];

    ctrl_t           ctrl_d_s;
    logic [3:0]      rd_d_s, rs1_d_s, rs2_d_s;
    logic [SIZE-1:0] imm_d_s, rd1_s, rd2_s, result_s;
    logic            wr_en_s;
    de_t             de_next_s;
    fwd_e            fwd_a_s, fwd_b_s;
    logic [SIZE-1:0] op_a_s, op_b_s, alu_b_s, alu_s, target_s;
    logic            taken_s, stall_s, flush_s;

    assign rd_d_s   = fd_r.instr[SIZE-5 -: 4];
    assign rs1_d_s  = fd_r.instr[SIZE-9 -: 4];
    assign rs2_d_s  = fd_r.instr[SIZE-13 -: 4];
    assign imm_d_s  = {{(SIZE-32){fd_r.instr[31]}}, fd_r.instr[31:0]};
    assign ctrl_d_s = decode_ctrl(fd_r.instr[SIZE-1 -: 4]);
    assign result_s = mw_r.mem_to_reg ? mw_r.rdata : mw_r.alu;
    assign wr_en_s  = mw_r.reg_write && (mw_r.rd != 4'd0);

    // Register-file read with write-through from the W stage.
    always_comb begin
        if (rs1_d_s == 4'd0) begin
            rd1_s = '0;
        end else if (wr_en_s && (mw_r.rd == rs1_d_s)) begin
            rd1_s = result_s;
        end else begin
            rd1_s = rf_r[rs1_d_s];
        end
        if (rs2_d_s == 4'd0) begin
            rd2_s = '0;
        end else if (wr_en_s && (mw_r.rd == rs2_d_s)) begin
            rd2_s = result_s;
        end else begin
            rd2_s = rf_r[rs2_d_s];
        end
        de_next_s = '{ctrl: ctrl_d_s, pc: fd_r.pc, rd1: rd1_s, rd2: rd2_s, imm: imm_d_s,
                      rd: rd_d_s, rs1: rs1_d_s, rs2: rs2_d_s};
    end

    cpu_hazard_unit u_hazard (
        .rs1_d      (rs1_d_s),
        .rs2_d      (rs2_d_s),
        .rs1_e      (de_r.rs1),
        .rs2_e      (de_r.rs2),
        .rd_e       (de_r.rd),
        .rd_m       (em_r.rd),
        .rd_w       (mw_r.rd),
        .load_e     (de_r.ctrl[CB_MEMTOREG]),
        .regwrite_m (em_r.ctrl[CB_REGWRITE]),
        .regwrite_w (mw_r.reg_write),
        .taken_e    (taken_s),
        .fwd_a      (fwd_a_s),
        .fwd_b      (fwd_b_s),
        .stall      (stall_s),
        .flush      (flush_s)
    );

    // E-stage operand muxing, ALU and branch resolution.
    always_comb begin
        case (fwd_a_s)
            FWD_M:   op_a_s = em_r.alu;
            FWD_W:   op_a_s = result_s;
            default: op_a_s = de_r.rd1;
        endcase
        case (fwd_b_s)
            FWD_M:   op_b_s = em_r.alu;
            FWD_W:   op_b_s = result_s;
            default: op_b_s = de_r.rd2;
        endcase
        alu_b_s = de_r.ctrl[CB_ALUSRC] ? de_r.imm : op_b_s;
        case (de_r.ctrl[1:0])
            ALU_ADD: alu_s = op_a_s + alu_b_s;
            ALU_SUB: alu_s = op_a_s - alu_b_s;
            ALU_AND: alu_s = op_a_s & alu_b_s;
            ALU_OR:  alu_s = op_a_s | alu_b_s;
            default: alu_s = op_a_s + alu_b_s;
        endcase
        taken_s  = de_r.ctrl[CB_BRANCH] && (alu_s == '0);
        target_s = de_r.pc + SIZE'(1'b1) + de_r.imm;
    end

    // Pipeline registers; a taken branch outranks a load-use stall.
    always_ff @(posedge MASTER_CLK or posedge Reset) begin
        if (Reset) begin
            pc_r <= '0;
            fd_r <= '0;
            de_r <= '0;
            em_r <= '0;
            mw_r <= '0;
        end else begin
            em_r <= '{ctrl: de_r.ctrl, alu: alu_s, wdata: op_b_s, rd: de_r.rd};
            mw_r <= '{reg_write: em_r.ctrl[CB_REGWRITE], mem_to_reg: em_r.ctrl[CB_MEMTOREG],
                      alu: em_r.alu, rdata: ReadDataM, rd: em_r.rd};
            if (flush_s) begin
                pc_r <= target_s;
                fd_r <= '0;
                de_r <= '0;
            end else if (stall_s) begin
                de_r <= '0;
            end else begin
                pc_r <= pc_r + SIZE'(1'b1);
                fd_r <= '{instr: Instr, pc: pc_r};
                de_r <= de_next_s;
            end
        end
    end

    // Register-file write at the end of W; contents are not reset.
    always_ff @(posedge MASTER_CLK) begin
        if (wr_en_s) begin
            rf_r[mw_r.rd] <= result_s;
        end
    end

    assign PCF           = pc_r;
    assign iD            = fd_r.instr;
    assign Ctrl_D        = ctrl_d_s;
    assign Ctrl_E        = de_r.ctrl;
    assign Ctrl_M        = em_r.ctrl;
    assign MemWriteM     = em_r.ctrl[CB_MEMWRITE];
    assign ALUOutM       = em_r.alu;
    assign WriteDataM    = em_r.wdata;
    assign MemoryControl = {em_r.ctrl[CB_MEMTOREG], em_r.ctrl[CB_MEMWRITE]};

endmodule

// File: tb/tb_cpu_pipelined.sv
// Directed testbench for cpu_pipelined: bench-side instruction ROM and data memory,
// hand-computed expectations checked with immediate assertions.
module tb_cpu_pipelined;

    logic        MASTER_CLK;
    logic        Reset;
    logic [47:0] Instr;
    logic [47:0] ReadDataM;
    logic        MemWriteM;
    logic [47:0] PCF;
    logic [47:0] ALUOutM;
    logic [47:0] WriteDataM;
    logic [1:0]  MemoryControl;
    logic [47:0] iD;
    logic [6:0]  Ctrl_D;
    logic [6:0]  Ctrl_E;
    logic [6:0]  Ctrl_M;

    logic [47:0] rom  [64];
    logic [47:0] dmem [16];
    int n_chk  = 0;
    int n_fail = 0;

    cpu_pipelined dut (
        .MASTER_CLK    (MASTER_CLK),
        .Reset         (Reset),
        .Instr         (Instr),
        .ReadDataM     (ReadDataM),
        .MemWriteM     (MemWriteM),
        .PCF           (PCF),
        .ALUOutM       (ALUOutM),
        .WriteDataM    (WriteDataM),
        .MemoryControl (MemoryControl),
        .iD            (iD),
        .Ctrl_D        (Ctrl_D),
        .Ctrl_E        (Ctrl_E),
        .Ctrl_M        (Ctrl_M)
    );

    initial MASTER_CLK = 1'b0;
    always #5 MASTER_CLK = ~MASTER_CLK;

    assign Instr     = (PCF < 48'd64) ? rom[PCF[5:0]] : 48'd0;
    assign ReadDataM = dmem[ALUOutM[3:0]];

    always @(posedge MASTER_CLK) begin
        if (MemWriteM) dmem[ALUOutM[3:0]] <= WriteDataM;
    end

    function automatic logic [47:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [31:0] imm);
        ins = {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge MASTER_CLK);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 48'd0;
    endtask

    // Hold reset across two edges, release between edges; next tick is edge 1.
    task automatic restart();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 48'd0;
        clear_rom();
        Reset = 1'b1;

        // Reset state and free-running PC
        tick();
        tick();
        chk("rst_pcf", PCF, 48'd0);
        chk("rst_iD", iD, 48'd0);
        chk("rst_ctrl", {27'd0, Ctrl_D, Ctrl_E, Ctrl_M}, 48'd0);
        chk("rst_memwr", {47'd0, MemWriteM}, 48'd0);
        chk("rst_memctl", {46'd0, MemoryControl}, 48'd0);
        chk("rst_aluout", ALUOutM, 48'd0);
        tick();
        Reset = 1'b0;
        chk("pc_before_edge", PCF, 48'd0);
        tick();
        chk("pc_seq1", PCF, 48'd1);
        tick();
        chk("pc_seq2", PCF, 48'd2);
        tick();
        chk("pc_seq3", PCF, 48'd3);

        // ALU hazard chain
        clear_rom();
        rom[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 32'd5);
        rom[1] = ins(4'd5, 4'd2, 4'd0, 4'd0, 32'd7);
        rom[2] = ins(4'd1, 4'd3, 4'd1, 4'd2, 32'd0);
        rom[3] = ins(4'd2, 4'd4, 4'd3, 4'd1, 32'd0);
        restart();
        tick();
        chk("alu_ctrl_d_addi", {41'd0, Ctrl_D}, 48'h48);
        tick();
        tick();
        chk("alu_m_5", ALUOutM, 48'd5);
        chk("alu_ctrl_d_add", {41'd0, Ctrl_D}, 48'h40);
        tick();
        chk("alu_m_7", ALUOutM, 48'd7);
        tick();
        chk("alu_m_12", ALUOutM, 48'd12);
        tick();
        chk("alu_m_sub7", ALUOutM, 48'd7);
        chk("alu_nostall_pc", PCF, 48'd6);
        tick();
        tick();
        chk("alu_r3", dut.rf_r[3], 48'd12);
        chk("alu_r4", dut.rf_r[4], 48'd7);

        // Store, load, load-use stall
        clear_rom();
        rom[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 32'd9);
        rom[1] = ins(4'd7, 4'd0, 4'd0, 4'd1, 32'd4);
        rom[2] = ins(4'd6, 4'd2, 4'd0, 4'd0, 32'd4);
        rom[3] = ins(4'd6, 4'd5, 4'd0, 4'd0, 32'd4);
        rom[4] = ins(4'd1, 4'd6, 4'd5, 4'd5, 32'd0);
        restart();
        repeat (4) tick();
        chk("st_memwr", {47'd0, MemWriteM}, 48'd1);
        chk("st_addr", ALUOutM, 48'd4);
        chk("st_data", WriteDataM, 48'd9);
        chk("st_memctl", {46'd0, MemoryControl}, 48'd1);
        tick();
        chk("ld_memctl", {46'd0, MemoryControl}, 48'd2);
        chk("ld_pc5", PCF, 48'd5);
        chk("ld_ctrl_e", {41'd0, Ctrl_E}, 48'h58);
        tick();
        chk("lu_pc_held", PCF, 48'd5);
        chk("lu_bubble", {41'd0, Ctrl_E}, 48'd0);
        chk("lu_iD_held", iD, ins(4'd1, 4'd6, 4'd5, 4'd5, 32'd0));
        tick();
        chk("lu_pc6", PCF, 48'd6);
        chk("ld_r2", dut.rf_r[2], 48'd9);
        chk("lu_ctrl_e_add", {41'd0, Ctrl_E}, 48'h40);
        tick();
        chk("lu_alu18", ALUOutM, 48'd18);
        tick();
        tick();
        chk("lu_r6", dut.rf_r[6], 48'd18);

        // Taken branch: BEQ R0,R0,+3 at PC 2
        clear_rom();
        rom[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 32'd1);
        rom[2] = ins(4'd8, 4'd0, 4'd0, 4'd0, 32'd3);
        rom[3] = ins(4'd5, 4'd7, 4'd0, 4'd0, 32'h11);
        rom[4] = ins(4'd5, 4'd8, 4'd0, 4'd0, 32'h22);
        rom[5] = ins(4'd5, 4'd9, 4'd0, 4'd0, 32'h33);
        rom[6] = ins(4'd5, 4'd10, 4'd0, 4'd0, 32'h44);
        restart();
        repeat (4) tick();
        chk("bt_pc4", PCF, 48'd4);
        chk("bt_ctrl_e_beq", {41'd0, Ctrl_E}, 48'h05);
        tick();
        chk("bt_pc_target", PCF, 48'd6);
        chk("bt_iD_flush", iD, 48'd0);
        chk("bt_ctrl_e_flush", {41'd0, Ctrl_E}, 48'd0);
        chk("bt_ctrl_m_beq", {41'd0, Ctrl_M}, 48'h05);
        tick();
        chk("bt_pc7", PCF, 48'd7);
        chk("bt_ctrl_e_flush2", {41'd0, Ctrl_E}, 48'd0);
        chk("bt_ctrl_m_flush1", {41'd0, Ctrl_M}, 48'd0);
        chk("bt_iD_target", iD, ins(4'd5, 4'd10, 4'd0, 4'd0, 32'h44));
        tick();
        chk("bt_ctrl_m_flush2", {41'd0, Ctrl_M}, 48'd0);
        tick();
        chk("bt_alu_target", ALUOutM, 48'h44);
        chk("bt_ctrl_m_addi", {41'd0, Ctrl_M}, 48'h48);

        // Not-taken branch: BEQ R1,R0 with R1=1
        rom[2] = ins(4'd8, 4'd0, 4'd1, 4'd0, 32'd3);
        restart();
        repeat (4) tick();
        chk("bn_ctrl_e_beq", {41'd0, Ctrl_E}, 48'h05);
        tick();
        chk("bn_pc5", PCF, 48'd5);
        chk("bn_ctrl_e_next", {41'd0, Ctrl_E}, 48'h48);
        tick();
        chk("bn_alu_11", ALUOutM, 48'h11);
        chk("bn_pc6", PCF, 48'd6);
        tick();
        chk("bn_alu_22", ALUOutM, 48'h22);

        // Asynchronous reset between edges
        clear_rom();
        rom[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 32'd5);
        rom[1] = ins(4'd5, 4'd2, 4'd0, 4'd0, 32'd7);
        rom[2] = ins(4'd1, 4'd3, 4'd1, 4'd2, 32'd0);
        restart();
        repeat (3) tick();
        chk("ar_pre_ctrl_m", {41'd0, Ctrl_M}, 48'h48);
        Reset = 1'b1;
        #1;
        chk("ar_pcf", PCF, 48'd0);
        chk("ar_ctrl", {27'd0, Ctrl_D, Ctrl_E, Ctrl_M}, 48'd0);
        chk("ar_memctl", {46'd0, MemoryControl}, 48'd0);
        chk("ar_aluout", ALUOutM, 48'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("ar_restart_pc1", PCF, 48'd1);
        chk("ar_restart_iD", iD, ins(4'd5, 4'd1, 4'd0, 4'd0, 32'd5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_pipelined.md
Name: cpu_pipelined

Overview:
- 5-stage in-order pipelined CPU (F, D, E, M, W) with a 48-bit datapath and 48-bit fixed-width instructions.
- Sits between an external instruction ROM and an external data memory.
- The instruction ROM returns Instr combinationally from PCF.
- The data memory reads combinationally from ALUOutM and writes on the rising edge when MemWriteM=1.
- Exposes decode-stage instruction and per-stage control words for debug.

Parameters:
- SIZE, 48, width of datapath, PC, instruction, and memory address/data buses.

Ports:
- MASTER_CLK  in  1  single clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all pipeline state.
- Instr  in  SIZE  instruction fetched at PCF.
- ReadDataM  in  SIZE  load data for the M-stage address.
- MemWriteM  out  1  store strobe (M stage).
- PCF  out  SIZE  fetch PC, word-indexed.
- ALUOutM  out  SIZE  M-stage ALU result; data memory address.
- WriteDataM  out  SIZE  store data (M stage).
- MemoryControl  out  2  {load_in_M, store_in_M}.
- iD  out  SIZE  instruction held in the F/D register.
- Ctrl_D  out  7  control word decoded from iD.
- Ctrl_E  out  7  control word held in the D/E register.
- Ctrl_M  out  7  control word held in the E/M register.

Behaviour:
- Interface: one clock MASTER_CLK; Reset is asynchronous and active-high.
- Reset state: PCF=0; all pipeline registers = 0 (iD=0 is a NOP, all Ctrl=0); MemWriteM=0, MemoryControl=0, ALUOutM=0, WriteDataM=0.
- Register file: 16 x SIZE, not reset.
  - R0 always reads 0; writes to R0 are ignored.
  - A W-stage write is visible to a same-cycle D-stage read (write-through).
- Instruction fields:
  - [47:44] opcode, [43:40] rd, [39:36] rs1, [35:32] rs2.
  - [31:0] imm, sign-extended to SIZE.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 ADDI rd=rs1+imm
  - 6 LDR rd=mem[rs1+imm]
  - 7 STR mem[rs1+imm]=rs2
  - 8 BEQ: if rs1==rs2 then PC=PC_E+1+imm
  - 9-15 decode as NOP
- Control word bits: [6] RegWrite, [5] MemWrite, [4] MemToReg, [3] ALUSrc(imm), [2] Branch, [1:0] ALUCtrl (00 add, 01 sub, 10 and, 11 or).
  - BEQ uses sub and tests the zero flag.
- Arithmetic: SIZE-bit wrap-around, no flags other than zero; no exceptions.
- PC: PCF increments by 1 per cycle unless stalled or redirected; wraps at 2^SIZE.
- Forwarding to E-stage operands:
  - Source is M (ALUOutM) if RegWrite_M and rd_M==rs and rs!=0.
  - Otherwise W (result) under the same condition.
  - Otherwise the register-file value.
  - M has priority over W.
  - WriteDataM carries the forwarded rs2.
- Load-use stall: when E holds LDR with rd_E!=0 and rd_E equals rs1_D or rs2_D:
  - hold PCF and the F/D register;
  - insert a bubble (all-zero control) into D/E;
  - one cycle.
- Branch: resolved in E. When taken, on that edge:
  - PCF <= target;
  - F/D and D/E are flushed to zero;
  - penalty is 2 cycles.
  - Not taken: no penalty.
- Stall and taken branch in the same cycle cannot coexist (E holds either a load or a branch). The flush rule is still given priority in RTL.
- Writeback: result = MemToReg_W ? ReadData_W : ALUOut_W, written at the end of W.
- Reset asserted mid-operation: all pipeline state clears immediately (asynchronous); execution restarts at PC 0 on the first edge after release.

Decomposition:
- cpu_pkg:
  - SIZE default;
  - opcode enum;
  - control-bit index constants;
  - ALUCtrl codes;
  - 7-bit ctrl_t typedef;
  - per-stage pipeline-register structs.
- One sub-module, cpu_hazard_unit: forwarding selects, stall, flush.
- Register file, ALU and decode stay inline.

Test Plan:
- Reset: Reset held 20 ns -> PCF=0, iD=0, Ctrl_D/E/M=0, MemWriteM=0. After release, PCF=0,1,2,... on successive edges.
- ALU hazard chain:
  - program: ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; SUB R4,R3,R1.
  - required: R3=12 via M/W forwarding, no stall.
  - required: R4=7, and ALUOutM shows 5, 7, 12, 7 in consecutive cycles.
- Store then load:
  - program: ADDI R1,R0,9; STR R1,[R0+4]; LDR R2,[R0+4].
  - required: MemWriteM=1 with ALUOutM=4, WriteDataM=9; later R2=9; MemoryControl=01 then 10.
- Load-use: LDR R5,[R0+4] followed by ADD R6,R5,R5 -> exactly one stall cycle (PCF held, Ctrl_E=0 bubble), then R6=18.
- Branch:
  - program: BEQ R0,R0,+3 at PC 2.
  - required: PCF jumps to 6; the two younger instructions are flushed (Ctrl_E=0, no RegWrite).
  - required: BEQ with unequal registers -> sequential flow, no bubble.
- Async reset mid-run: assert Reset between clock edges -> PCF and all Ctrl outputs go to 0 without waiting for MASTER_CLK.
